trifid_decoder: RTL

Streaming decoder for the team's trifid-style letter code: accepts 2-bit trits serially and regroups every three into a 6-bit code. Each code is translated back to its ASCII character (A–Z or '.') and buffered in a small output FIFO with a valid/ready handshake. Sits at the receive end of the link fed by the letter encoder, between the symbol deserializer and the character consumer (display/UART path).

---
 rtl/trifid_pkg.sv | 53 +++++
 rtl/trifid_decoder_char_fifo.sv | 53 +++++
 rtl/trifid_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/trifid_pkg.sv
// Shared definitions for the trifid letter code: trit encodings, assembly
// FSM states and the code-to-ASCII translation table.
package trifid_pkg;

  localparam logic [1:0] TRIT_1   = 2'b00;
  localparam logic [1:0] TRIT_2   = 2'b01;
  localparam logic [1:0] TRIT_3   = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  typedef enum logic [1:0] {
    S_T1 = 2'd0,
    S_T2 = 2'd1,
    S_T3 = 2'd2
  } asm_state_t;

  // Only legal trits reach this function, so the 27 listed codes are the
  // complete input set; the default arm just keeps the logic fully specified.
  function automatic logic [7:0] code_to_ascii(input logic [5:0] code);
    logic [7:0] ch;
    case (code)
      6'b101001: ch = 8'h41; // A
      6'b000110: ch = 8'h42; // B
      6'b001001: ch = 8'h43; // C
      6'b010101: ch = 8'h44; // D
      6'b100000: ch = 8'h45; // E
      6'b000000: ch = 8'h46; // F
      6'b010001: ch = 8'h47; // G
      6'b100101: ch = 8'h48; // H
      6'b101010: ch = 8'h49; // I
      6'b000100: ch = 8'h4A; // J
      6'b100110: ch = 8'h4B; // K
      6'b011000: ch = 8'h4C; // L
      6'b010010: ch = 8'h4D; // M
      6'b100001: ch = 8'h4E; // N
      6'b001000: ch = 8'h4F; // O
      6'b011001: ch = 8'h50; // P
      6'b101000: ch = 8'h51; // Q
      6'b000001: ch = 8'h52; // R
      6'b001010: ch = 8'h53; // S
      6'b011010: ch = 8'h54; // T
      6'b100100: ch = 8'h55; // U
      6'b010000: ch = 8'h56; // V
      6'b010110: ch = 8'h57; // W
      6'b000101: ch = 8'h58; // X
      6'b000010: ch = 8'h59; // Y
      6'b010100: ch = 8'h5A; // Z
      6'b100010: ch = 8'h2E; // '.'
      default:   ch = 8'h00;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/trifid_decoder_char_fifo.sv
// Small synchronous FIFO holding decoded characters for the consumer.
// Head reads as 8'h00 whenever the FIFO is empty.
module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Storage, pointers and occupancy; reset discards every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trifid_decoder.sv
// Trifid decoder: gathers three serial trits into a 6-bit code, translates
// it to ASCII and queues the character for the consumer.
//
// state | meaning
// S_T1  | waiting for first trit of a group
// S_T2  | first trit held, waiting for second
// S_T3  | two trits held, third completes the group (stalls when FIFO full)
module trifid_decoder
  import trifid_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_valid,
  input  logic [1:0]               sym,
  output logic                     sym_ready,
  input  logic                     frame_clr,
  output logic                     char_valid,
  output logic [7:0]               char_data,
  input  logic                     char_ready,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   level
);

  asm_state_t state, state_next;
  logic [1:0] t1, t2;
  logic       load_t1, load_t2;
  logic       push;
  logic       err_next;
  logic       accept;
  logic       full, empty;
  logic [7:0] push_data;

  // full is derived from registered occupancy, so no path from char_ready.
  assign sym_ready  = (state != S_T3) || !full;
  assign accept     = sym_valid && sym_ready;
  assign push_data  = code_to_ascii({t1, t2, sym});
  assign char_valid = !empty;

  // State, partial-group trits and registered error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_T1;
      t1    <= TRIT_1;
      t2    <= TRIT_1;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (load_t1) t1 <= sym;
      if (load_t2) t2 <= sym;
    end
  end

  // Next-state and push decisions; a frame clear overrides any trit.
  always_comb begin
    state_next = state;
    load_t1    = 1'b0;
    load_t2    = 1'b0;
    push       = 1'b0;
    err_next   = 1'b0;
    if (frame_clr) begin
      state_next = S_T1;
    end else if (accept) begin
      if (sym == TRIT_BAD) begin
        err_next   = 1'b1;
        state_next = S_T1;
      end else begin
        case (state)
          S_T1: begin
            load_t1    = 1'b1;
            state_next = S_T2;
          end
          S_T2: begin
            load_t2    = 1'b1;
            state_next = S_T3;
          end
          S_T3: begin
            push       = 1'b1;
            state_next = S_T1;
          end
          default: state_next = S_T1;
        endcase
      end
    end
  end

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (char_ready),
    .head      (char_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

endmodule
